nand_cmd_addr_seq: RTL

NAND_CMD_ADDR_SEQ -- requirements
Module: nand_cmd_addr_seq

---
 rtl/nand_phy_pkg.sv | 28 ++
 rtl/nand_cmd_addr_seq.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/nand_phy_pkg.sv
// Shared definitions for the NAND PHY command/address latch path:
// sequencer state encoding, timing counter width and default timings.
package nand_phy_pkg;

  // Width of the per-phase timing down-counter (timings are 1..15 cycles).
  localparam int CNT_W = 4;

  // Default parameterisation of the command/address sequencer.
  localparam int DEF_CENS_PER_IO = 2;
  localparam int DEF_T_SETUP     = 2;
  localparam int DEF_T_WP        = 2;
  localparam int DEF_T_WH        = 2;

  // Latch-cycle phases: SETUP (bus stable, WE# high), WLOW (WE# low),
  // HOLD (WE# high again, bus still held).
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_WLOW  = 2'd2,
    ST_HOLD  = 2'd3
  } nand_state_e;

  // Width of a chip-enable index; at least one bit even for a single CE.
  function automatic int ce_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/nand_cmd_addr_seq.sv
// Command/address latch sequencer for one NAND IO half. Each accepted
// request produces one CLE or ALE latch cycle with programmable setup,
// WE# low and hold times, and manages the chip enables across requests.
// All outputs are registered and go straight to the IOB flop stage.
module nand_cmd_addr_seq
  import nand_phy_pkg::*;
#(
  parameter int CENS_PER_IO = DEF_CENS_PER_IO,
  parameter int T_SETUP     = DEF_T_SETUP,
  parameter int T_WP        = DEF_T_WP,
  parameter int T_WH        = DEF_T_WH,
  localparam int CE_W       = ce_width(CENS_PER_IO)
) (
  input  logic                   clk0,
  input  logic                   rst0_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_is_addr,
  input  logic [7:0]             req_data,
  input  logic [CE_W-1:0]        req_ce,
  input  logic                   req_last,
  input  logic                   wp_n_req,
  output logic                   ctrl_cle,
  output logic                   ctrl_ale,
  output logic                   ctrl_wrn,
  output logic                   ctrl_wpn,
  output logic [CENS_PER_IO-1:0] ctrl_cen,
  output logic [7:0]             dq_out,
  output logic                   dq_oe,
  output logic                   busy
);

  localparam logic [1:0] S_IDLE  = ST_IDLE;
  localparam logic [1:0] S_SETUP = ST_SETUP;
  localparam logic [1:0] S_WLOW  = ST_WLOW;
  localparam logic [1:0] S_HOLD  = ST_HOLD;

  localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(T_SETUP - 1);
  localparam logic [CNT_W-1:0] LD_WP    = CNT_W'(T_WP - 1);
  localparam logic [CNT_W-1:0] LD_WH    = CNT_W'(T_WH - 1);

  logic [1:0]             state_reg;
  logic [CNT_W-1:0]       cnt_reg;
  logic                   last_reg;
  logic                   rdy_en_reg;
  logic                   cle_reg;
  logic                   ale_reg;
  logic                   wrn_reg;
  logic                   wpn_reg;
  logic [CENS_PER_IO-1:0] cen_reg;
  logic [7:0]             dq_reg;
  logic                   oe_reg;

  // Active-low one-hot of the requested CE; an out-of-range index matches
  // nothing, so every CE# stays high for that request.
  logic [CENS_PER_IO-1:0] sel_cen_n;
  for (genvar gi = 0; gi < CENS_PER_IO; gi++) begin : g_ce_dec
    assign sel_cen_n[gi] = (req_ce != CE_W'(gi));
  end

  // Latch-cycle FSM with shared down-counter; drives all IOB-bound controls.
  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) begin
      state_reg  <= S_IDLE;
      cnt_reg    <= '0;
      last_reg   <= 1'b0;
      rdy_en_reg <= 1'b0;
      cle_reg    <= 1'b0;
      ale_reg    <= 1'b0;
      wrn_reg    <= 1'b1;
      wpn_reg    <= 1'b0;
      cen_reg    <= '1;
      dq_reg     <= 8'h00;
      oe_reg     <= 1'b0;
    end else begin
      // Ready is held off for the first edge after reset release.
      rdy_en_reg <= 1'b1;
      case (state_reg)
        S_IDLE: begin
          // Write protect only follows its request between latch cycles.
          wpn_reg <= wp_n_req;
          if (req_valid && rdy_en_reg) begin
            state_reg <= S_SETUP;
            cnt_reg   <= LD_SETUP;
            last_reg  <= req_last;
            cle_reg   <= ~req_is_addr;
            ale_reg   <= req_is_addr;
            dq_reg    <= req_data;
            oe_reg    <= 1'b1;
            // Replaces any CE held from a previous request on the same edge.
            cen_reg   <= sel_cen_n;
          end
        end
        S_SETUP: begin
          if (cnt_reg == '0) begin
            state_reg <= S_WLOW;
            cnt_reg   <= LD_WP;
            wrn_reg   <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        S_WLOW: begin
          if (cnt_reg == '0) begin
            state_reg <= S_HOLD;
            cnt_reg   <= LD_WH;
            wrn_reg   <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        S_HOLD: begin
          if (cnt_reg == '0) begin
            state_reg <= S_IDLE;
            cle_reg   <= 1'b0;
            ale_reg   <= 1'b0;
            oe_reg    <= 1'b0;
            if (last_reg) begin
              cen_reg <= '1;
            end
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready = rdy_en_reg && (state_reg == S_IDLE);
  assign busy      = (state_reg != S_IDLE) || !(&cen_reg);
  assign ctrl_cle  = cle_reg;
  assign ctrl_ale  = ale_reg;
  assign ctrl_wrn  = wrn_reg;
  assign ctrl_wpn  = wpn_reg;
  assign ctrl_cen  = cen_reg;
  assign dq_out    = dq_reg;
  assign dq_oe     = oe_reg;

endmodule
